sram_req_ctrl: RTL
==================

Name: sram_req_ctrl

Overview:
Request-side controller sitting directly upstream of the banked 512x512b SRAM macro. It converts a valid/ready request stream (read or masked write) into the SRAM's raw address, data and write-enable ports. It absorbs the SRAM's fixed 1-cycle read latency and returns read data on a valid/ready response stream with backpressure. It also sequences SRAM start-up after reset.

Parameters:
WIDTH, 512, row width in bits; must be a multiple of WORD_SIZE
LOG_NUM_ROWS, 9, address width; NUM_ROWS = 2**LOG_NUM_ROWS
WORD_SIZE, 64, write-enable granule in bits; NWORDS = WIDTH/WORD_SIZE
TAG_W, 4, width of the opaque request tag returned with each read response

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init_done  out  1  high once the controller accepts requests
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  LOG_NUM_ROWS  row address
req_wdata  in  WIDTH  write data
req_wmask  in  NWORDS  per-word write mask; ignored for reads
req_tag  in  TAG_W  tag echoed on the read response
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  read data
rsp_tag  out  TAG_W  tag of the originating read
sram_readAddr  out  LOG_NUM_ROWS  to SRAM readAddr
sram_readData  in  WIDTH  from SRAM readData, valid 1 cycle after the address
sram_writeAddr  out  LOG_NUM_ROWS  to SRAM writeAddr
sram_writeData  out  WIDTH  to SRAM writeData
sram_writeEnable  out  NWORDS  to SRAM writeEnable

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. The SRAM shares the same reset.
- Reset values:
  - init_done=0, req_ready=0, rsp_valid=0, sram_writeEnable=0.
  - Response FIFO is emptied. The in-flight read flag s1_valid is cleared.
  - Reset asserted mid-operation discards all in-flight reads and queued responses; no partial response is emitted.
- FSM states: RESET_WAIT, INIT, RUN.
  - While reset is high the FSM is held in RESET_WAIT.
  - RESET_WAIT lasts one cycle after reset deasserts, covering the SRAM's own reset fill. It then moves to INIT if SRAM_REQ_CTRL_ZERO_INIT_EN is defined, otherwise to RUN.
  - INIT behaviour is defined under Optional Feature.
  - init_done = (state==RUN). It is registered.
- RUN, accept rule:
  - pop = rsp_valid & rsp_ready.
  - req_ready = (fifo_cnt + s1_valid - pop) < 2, computed combinationally.
  - Outside RUN, req_ready=0.
- Writes (accepted request with req_write=1):
  - In the same cycle, drive sram_writeAddr=req_addr, sram_writeData=req_wdata, sram_writeEnable=req_wmask.
  - The SRAM commits the write at the next clock edge. No response is generated.
  - A write with mask 0 is legal and is a no-op.
- Reads (accepted request with req_write=0):
  - In the same cycle, drive sram_readAddr=req_addr and register s1_valid=1 and s1_tag=req_tag.
  - In the next cycle, push {sram_readData, s1_tag} into the response FIFO.
  - Minimum request-to-rsp_valid latency is 2 cycles.
- When no write is accepted, sram_writeEnable=0. When no read is accepted, sram_readAddr holds its last value.
- Ordering and hazards:
  - Only one request is accepted per cycle, so a read accepted the cycle after a write to the same row returns the new data.
  - Responses are returned in request order.
- Response FIFO:
  - 2 entries. rsp_valid = fifo_cnt != 0. rsp_data and rsp_tag come from the head entry.
  - Push and pop in the same cycle are allowed, including at cnt=1.
  - No push ever occurs when cnt=2 and there is no pop; this is guaranteed by the accept rule. Overflow is an assertion failure.
- Full throughput: one read per cycle is sustained when rsp_ready is held at 1.

Optional Feature:
SRAM_REQ_CTRL_ZERO_INIT_EN
- Defined:
  - The INIT state walks a row counter from 0 to NUM_ROWS-1, one row per cycle.
  - Each cycle drives sram_writeAddr=counter, sram_writeData=0, sram_writeEnable=all ones.
  - After the row NUM_ROWS-1 write, the FSM moves to RUN. init_done rises NUM_ROWS+2 cycles after reset deasserts.
- Not defined: there is no INIT state. init_done rises 2 cycles after reset deasserts, and memory contents are whatever the SRAM's reset fill leaves.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state_t enum {RESET_WAIT, INIT, RUN};
  - default constants for WIDTH, LOG_NUM_ROWS, WORD_SIZE, TAG_W;
  - the rsp_entry_t struct {data, tag}.
- One sub-module: sram_rsp_fifo, a parameterised 2-entry FIFO with push/pop/cnt.

Test Plan:
- Reset, macro off -> init_done=0 for 2 cycles after reset deasserts, then 1; rsp_valid=0 and sram_writeEnable=0 throughout.
- Write addr 5, data 0xA5.., mask 0xFF; next cycle read addr 5 with tag 3 -> rsp_valid 2 cycles after the read is accepted, rsp_data=0xA5.., rsp_tag=3.
- Write addr 7 with full data 0x11.., then write addr 7 with data 0x22.. and mask 0x01; read addr 7 -> word0=0x22.., words1-7=0x11...
- rsp_ready=1, reads of addr 0..15 back-to-back -> req_ready stays 1; 16 in-order responses, one per cycle.
- rsp_ready=0, issue 3 reads -> first two accepted, req_ready=0 on the third. Raise rsp_ready -> the third read is accepted the same cycle, no loss and no duplicate.
- Macro on, LOG_NUM_ROWS=4 -> 16 init writes of 0 with enable 0xFF, init_done rises at cycle 18; a read of any row returns 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM request controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT,
    INIT,
    RUN
  } state_t;

  localparam int unsigned DEF_WIDTH        = 512;
  localparam int unsigned DEF_LOG_NUM_ROWS = 9;
  localparam int unsigned DEF_WORD_SIZE    = 64;
  localparam int unsigned DEF_TAG_W        = 4;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response FIFO; the entry type is a parameter so the top can size it.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter type entry_t = rsp_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  entry_t     data_i,
  input  logic       pop_i,
  output entry_t     data_o,
  output logic [1:0] cnt_o
);

  entry_t     mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i)  rd_q <= ~rd_q;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop_i && cnt_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && cnt_q == 2'd0));

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the banked SRAM: valid/ready requests in, 1-cycle-latency
// reads returned through a 2-entry response FIFO. SRAM_REQ_CTRL_ZERO_INIT_EN adds a zero-fill pass.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LOG_NUM_ROWS = DEF_LOG_NUM_ROWS,
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned TAG_W        = DEF_TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        init_done,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [LOG_NUM_ROWS-1:0]     req_addr,
  input  logic [WIDTH-1:0]            req_wdata,
  input  logic [WIDTH/WORD_SIZE-1:0]  req_wmask,
  input  logic [TAG_W-1:0]            req_tag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_data,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [LOG_NUM_ROWS-1:0]     sram_readAddr,
  input  logic [WIDTH-1:0]            sram_readData,
  output logic [LOG_NUM_ROWS-1:0]     sram_writeAddr,
  output logic [WIDTH-1:0]            sram_writeData,
  output logic [WIDTH/WORD_SIZE-1:0]  sram_writeEnable
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  state_t                  state_q, state_d;
  logic                    init_done_q;
  logic                    s1_valid_q;
  logic [TAG_W-1:0]        s1_tag_q;
  logic [LOG_NUM_ROWS-1:0] raddr_q;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
  logic [LOG_NUM_ROWS-1:0] row_q;
`endif

  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic       pop, req_acc, wr_acc, rd_acc;
  rsp_t       push_entry, head;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_WAIT: begin
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        state_d = INIT;
`else
        state_d = RUN;
`endif
      end
      INIT: begin
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
        if (row_q == '1) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      default: state_d = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_WAIT;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_q == RUN);
      s1_valid_q  <= rd_acc;
      if (rd_acc) begin
        s1_tag_q <= req_tag;
        raddr_q  <= req_addr;
      end
    end
  end

`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
  always_ff @(posedge clk) begin
    if (reset || state_q != INIT) row_q <= '0;
    else                          row_q <= row_q + LOG_NUM_ROWS'(1);
  end
`endif

  // Acceptance is gated on init_done so it never leads the advertised ready flag.
  always_comb begin
    pop       = (fifo_cnt != 2'd0) && rsp_ready;
    occ       = {1'b0, fifo_cnt} + 3'(s1_valid_q) - 3'(pop);
    req_ready = init_done_q && (occ < 3'd2);
    req_acc   = req_valid && req_ready;
    wr_acc    = req_acc && req_write;
    rd_acc    = req_acc && !req_write;
  end

  always_comb begin
    sram_writeAddr   = req_addr;
    sram_writeData   = req_wdata;
    sram_writeEnable = wr_acc ? req_wmask : '0;
    sram_readAddr    = rd_acc ? req_addr : raddr_q;
`ifdef SRAM_REQ_CTRL_ZERO_INIT_EN
    if (state_q == INIT) begin
      sram_writeAddr   = row_q;
      sram_writeData   = '0;
      sram_writeEnable = '1;
    end
`endif
  end

  assign push_entry = '{data: sram_readData, tag: s1_tag_q};

  sram_rsp_fifo #(
    .entry_t(rsp_t)
  ) u_rsp_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (s1_valid_q),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head),
    .cnt_o  (fifo_cnt)
  );

  assign init_done = init_done_q;
  assign rsp_valid = (fifo_cnt != 2'd0);
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;

endmodule
